pea_result_drain: RTL and testbench

//  Consumer end of the PEA output path. Pops paired entries from the result and status

---
 rtl/pea_result_drain.sv | 138 +++++++++++++
 tb/tb_pea_result_drain.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pea_result_drain.sv
// pea_result_drain
//   Consumer end of the PEA output path. The result and status output FIFOs
//   are written together, so their entries form pairs. This block pops one
//   pair at a time, waits for the registered FIFO read data, captures it, and
//   presents it to the host over a valid/ready handshake. It also counts the
//   pairs the host accepts, counts those flagged as errors, and raises a
//   sticky flag if the two FIFOs ever disagree about being empty.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   drain_en      permit popping; only looked at while idle
//   result_pop    population of the result FIFO
//   status_pop    population of the status FIFO
//   data_result   result FIFO read data, valid the cycle after rd_en
//   data_status   status FIFO read data, same timing
//   rd_en_result  result FIFO pop strobe (registered)
//   rd_en_status  status FIFO pop strobe (registered, always equals rd_en_result)
//   out_valid     out_result/out_status hold a pair for the host
//   out_ready     host accepts the pair on a rising edge with out_valid high
//   out_result    captured result word
//   out_status    captured status word
//   busy          a pair is in progress
//   pair_count    pairs accepted by the host, saturating
//   err_count     accepted pairs whose status error bit was set, saturating
//   desync        sticky: exactly one FIFO reported empty at some point

module pea_result_drain #(
  parameter int WIDTH   = 32,
  parameter int POP_W   = 5,
  parameter int CNT_W   = 16,
  parameter int ERR_BIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             drain_en,
  input  logic [POP_W-1:0] result_pop,
  input  logic [POP_W-1:0] status_pop,
  input  logic [WIDTH-1:0] data_result,
  input  logic [WIDTH-1:0] data_status,
  output logic             rd_en_result,
  output logic             rd_en_status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_status,
  output logic             busy,
  output logic [CNT_W-1:0] pair_count,
  output logic [CNT_W-1:0] err_count,
  output logic             desync
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_SHOW
  } state_t;

  state_t state;
  state_t state_next;
  logic   rd_en_q;
  logic   launch;
  logic   accept;
  logic   one_empty;

  // A pop may only start when both FIFOs hold at least one entry, so
  // neither FIFO can underflow even while the desync flag is set.
  assign launch    = drain_en && (result_pop != '0) && (status_pop != '0);
  assign accept    = (state == S_SHOW) && out_ready;
  assign one_empty = (result_pop == '0) != (status_pop == '0);

  // One strobe register feeds both FIFO read enables so they cannot differ.
  assign rd_en_result = rd_en_q;
  assign rd_en_status = rd_en_q;
  assign busy         = (state != S_IDLE);

  // Next-state logic: one pop, one settle cycle for the registered FIFO
  // output, then hold the pair until the host takes it.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (launch)    state_next = S_POP;
      S_POP:                 state_next = S_WAIT;
      S_WAIT:                state_next = S_SHOW;
      S_SHOW: if (out_ready) state_next = S_IDLE;
      default:               state_next = S_IDLE;
    endcase
  end

  // State register plus the registered strobes. rd_en and out_valid are
  // decoded from the next state so they come straight out of flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rd_en_q   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      rd_en_q   <= (state_next == S_POP);
      out_valid <= (state_next == S_SHOW);
    end
  end

  // Host data is captured only at the end of the settle cycle, so it never
  // changes while out_valid is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_result <= '0;
      out_status <= '0;
    end else if (state == S_WAIT) begin
      out_result <= data_result;
      out_status <= data_status;
    end
  end

  // Counters stop at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_count <= '0;
      err_count  <= '0;
    end else if (accept) begin
      if (pair_count != '1)
        pair_count <= pair_count + CNT_W'(1);
      if (out_status[ERR_BIT] && (err_count != '1))
        err_count <= err_count + CNT_W'(1);
    end
  end

  // Sticky desynchronisation flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      desync <= 1'b0;
    else if (one_empty)
      desync <= 1'b1;
  end

endmodule

// File: tb/tb_pea_result_drain.sv
// tb_pea_result_drain
//   Drives pea_result_drain from a pair of queue-based FIFO models and
//   scores every pair the host accepts against the order the pairs were
//   written. Counters are narrowed so that saturation is reached quickly.

module tb_pea_result_drain;

  localparam int WIDTH   = 32;
  localparam int POP_W   = 5;
  localparam int CNT_W   = 4;
  localparam int ERR_BIT = 0;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             drain_en;
  logic [POP_W-1:0] result_pop;
  logic [POP_W-1:0] status_pop;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_status;
  logic             rd_en_result;
  logic             rd_en_status;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_status;
  logic             busy;
  logic [CNT_W-1:0] pair_count;
  logic [CNT_W-1:0] err_count;
  logic             desync;

  always #5 clk = ~clk;

  pea_result_drain #(
    .WIDTH  (WIDTH),
    .POP_W  (POP_W),
    .CNT_W  (CNT_W),
    .ERR_BIT(ERR_BIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .drain_en    (drain_en),
    .result_pop  (result_pop),
    .status_pop  (status_pop),
    .data_result (data_result),
    .data_status (data_status),
    .rd_en_result(rd_en_result),
    .rd_en_status(rd_en_status),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_status  (out_status),
    .busy        (busy),
    .pair_count  (pair_count),
    .err_count   (err_count),
    .desync      (desync)
  );

  // FIFO contents and the scoreboard of pairs still owed to the host
  logic [WIDTH-1:0] rq[$];
  logic [WIDTH-1:0] sq[$];
  logic [WIDTH-1:0] exp_r[$];
  logic [WIDTH-1:0] exp_s[$];
  int               hs_edges[$];

  int checks = 0;
  int errors = 0;
  int model_pairs = 0;
  int model_errs = 0;
  int hs_total = 0;
  int edge_no = 0;
  int last_rd_edge = -100;
  int rd_pulses = 0;
  int rd_base;
  int base_total;
  int pushed;
  bit force_pop = 1'b0;
  bit found;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic update_pops();
    if (!force_pop) begin
      result_pop = (rq.size() > 31) ? 5'd31 : 5'(rq.size());
      status_pop = (sq.size() > 31) ? 5'd31 : 5'(sq.size());
    end
  endtask

  // Write one pair into both FIFOs, as the PEA wr_out strobe would.
  task automatic apply_stimulus(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] s);
    rq.push_back(r);
    sq.push_back(s);
    exp_r.push_back(r);
    exp_s.push_back(s);
    update_pops();
  endtask

  // One clock: score a handshake at this edge, model the FIFO read port,
  // then check the protocol rules on the new outputs.
  task automatic step();
    logic             pre_valid;
    logic             pre_ready;
    logic             pre_rd;
    logic             hs;
    logic [WIDTH-1:0] pre_r;
    logic [WIDTH-1:0] pre_s;
    logic [WIDTH-1:0] er;
    logic [WIDTH-1:0] es;
    pre_valid = out_valid;
    pre_ready = out_ready;
    pre_rd    = rd_en_result;
    pre_r     = out_result;
    pre_s     = out_status;
    hs        = pre_valid && pre_ready;
    if (pre_rd)
      check_output("pop_nonempty", 64'(rq.size() != 0 && sq.size() != 0), 1);
    if (hs) begin
      hs_total++;
      hs_edges.push_back(edge_no + 1);
      check_output("pair_expected", 64'(exp_r.size() != 0), 1);
      if (exp_r.size() != 0) begin
        er = exp_r.pop_front();
        es = exp_s.pop_front();
        check_output("pair_result", pre_r, er);
        check_output("pair_status", pre_s, es);
        if (model_pairs < CNT_MAX) model_pairs++;
        if (es[ERR_BIT] && model_errs < CNT_MAX) model_errs++;
      end
    end
    @(posedge clk);
    edge_no++;
    #1;
    if (pre_rd && rq.size() != 0 && sq.size() != 0) begin
      data_result = rq.pop_front();
      data_status = sq.pop_front();
    end
    update_pops();
    check_output("rd_en_equal", rd_en_status, rd_en_result);
    if (rd_en_result) begin
      rd_pulses++;
      last_rd_edge = edge_no;
      check_output("rd_single_pulse", pre_rd, 0);
      check_output("rd_not_showing", out_valid, 0);
    end
    if (out_valid && !pre_valid)
      check_output("latency", 64'(edge_no - last_rd_edge), 2);
    if (pre_valid && !pre_ready) begin
      check_output("hold_valid", out_valid, 1);
      check_output("hold_result", out_result, pre_r);
      check_output("hold_status", out_status, pre_s);
    end
    if (hs) check_output("valid_drop", out_valid, 0);
    if (out_valid) check_output("busy_show", busy, 1);
    check_output("pair_count", pair_count, model_pairs);
    check_output("err_count", err_count, model_errs);
  endtask

  task automatic run_until(input int target, input int budget);
    int n;
    n = 0;
    while (hs_total < target && n < budget) begin
      step();
      n++;
    end
    check_output("drain_budget", 64'(hs_total >= target), 1);
  endtask

  initial begin
    rst         = 1'b0;
    drain_en    = 1'b1;
    out_ready   = 1'b0;
    data_result = '0;
    data_status = '0;
    force_pop   = 1'b1;
    result_pop  = 5'd3;
    status_pop  = 5'd3;

    // Reset held with work apparently pending
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_rd_result", rd_en_result, 0);
    check_output("rst_rd_status", rd_en_status, 0);
    check_output("rst_valid", out_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_pairs", pair_count, 0);
    check_output("rst_errs", err_count, 0);
    check_output("rst_desync", desync, 0);
    check_output("rst_out_result", out_result, 0);
    check_output("rst_out_status", out_status, 0);

    @(negedge clk);
    rst       = 1'b1;
    force_pop = 1'b0;
    drain_en  = 1'b0;
    update_pops();

    // Single pair
    $display("[TB] single pair");
    apply_stimulus(32'h0000_0019, 32'h0000_0000);
    drain_en  = 1'b1;
    out_ready = 1'b1;
    run_until(1, 20);
    check_output("t2_pairs", pair_count, 1);
    check_output("t2_errs", err_count, 0);

    // Backpressure: only one pop while the host stalls
    $display("[TB] backpressure");
    out_ready = 1'b0;
    apply_stimulus($urandom, $urandom & 32'hFFFF_FFFE);
    apply_stimulus($urandom, $urandom & 32'hFFFF_FFFE);
    rd_base = rd_pulses;
    repeat (14) step();
    check_output("t3_one_pop", 64'(rd_pulses - rd_base), 1);
    check_output("t3_valid_held", out_valid, 1);
    hs_edges.delete();
    out_ready = 1'b1;
    run_until(3, 30);
    check_output("t3_hs_seen", 64'(hs_edges.size()), 2);
    if (hs_edges.size() == 2)
      check_output("t3_throughput", 64'(hs_edges[1] - hs_edges[0]), 4);

    // Error counting
    $display("[TB] error count");
    apply_stimulus($urandom, 32'h1);
    apply_stimulus($urandom, 32'h0);
    apply_stimulus($urandom, 32'h1);
    run_until(6, 40);
    check_output("t4_pairs", pair_count, 6);
    check_output("t4_errs", err_count, 2);

    // Random traffic, long enough to saturate the narrow counters
    $display("[TB] random traffic");
    pushed = 0;
    for (int c = 0; c < 600 && (pushed < 20 || exp_r.size() != 0 || out_valid); c++) begin
      if (pushed < 20 && $urandom_range(0, 2) == 0) begin
        apply_stimulus($urandom, $urandom);
        pushed++;
      end
      out_ready = 1'($urandom_range(0, 1));
      drain_en  = ($urandom_range(0, 3) != 0);
      step();
    end
    drain_en  = 1'b1;
    out_ready = 1'b1;
    run_until(26, 80);
    check_output("sat_pairs", pair_count, CNT_MAX);

    // Empty FIFOs and one-sided emptiness
    $display("[TB] desync and empty");
    rd_base = rd_pulses;
    repeat (6) step();
    check_output("t5_empty_no_pop", 64'(rd_pulses - rd_base), 0);
    force_pop  = 1'b1;
    result_pop = 5'd1;
    status_pop = 5'd0;
    repeat (4) step();
    check_output("t5_desync_set", desync, 1);
    check_output("t5_desync_no_pop", 64'(rd_pulses - rd_base), 0);
    force_pop = 1'b0;
    update_pops();
    repeat (3) step();
    check_output("t5_desync_sticky", desync, 1);
    drain_en = 1'b0;
    apply_stimulus($urandom, $urandom);
    repeat (8) step();
    check_output("t5_gated_no_pop", 64'(rd_pulses - rd_base), 0);
    drain_en = 1'b1;
    run_until(27, 20);

    // Reset during the settle cycle
    $display("[TB] reset mid-operation");
    apply_stimulus($urandom, $urandom);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      found = rd_en_result;
    end
    check_output("t6_pop_seen", found, 1);
    step();
    #2;
    rst = 1'b0;
    #1;
    check_output("t6_rd", rd_en_result, 0);
    check_output("t6_valid", out_valid, 0);
    check_output("t6_busy", busy, 0);
    check_output("t6_pairs", pair_count, 0);
    check_output("t6_errs", err_count, 0);
    check_output("t6_desync", desync, 0);
    check_output("t6_out_result", out_result, 0);
    rq.delete();
    sq.delete();
    exp_r.delete();
    exp_s.delete();
    model_pairs = 0;
    model_errs  = 0;
    data_result = '0;
    data_status = '0;
    update_pops();
    @(negedge clk);
    rst = 1'b1;
    base_total = hs_total;
    apply_stimulus(32'hCAFE_0001, 32'h1);
    run_until(base_total + 1, 20);
    check_output("t6_restart_pairs", pair_count, 1);
    check_output("t6_restart_errs", err_count, 1);
    check_output("t6_restart_desync", desync, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
